// File: rtl/window_peak_finder_pkg.sv
// rtl/window_peak_finder_pkg.sv - default geometry, derived widths and stage-1 payload for window_peak_finder
package window_pkg;
    localparam int DEF_W    = 8;
    localparam int DEF_N    = 16;
    localparam int DEF_L    = 80;
    localparam int DEF_ROWS = 150;

    localparam int COLSUM_W = DEF_W + $clog2(DEF_N);
    localparam int WINSUM_W = DEF_W + 2 * $clog2(DEF_N);
    localparam int COL_W    = $clog2(DEF_L);
    localparam int ROW_W    = $clog2(DEF_ROWS);

    // Fields are sized for the default geometry; smaller L/ROWS overrides zero-extend into them.
    typedef struct packed {
        logic [COLSUM_W-1:0] sum;
        logic [COL_W-1:0]    col;
        logic [ROW_W-1:0]    row;
        logic                last;
    } col_beat_t;
endpackage

// File: rtl/window_peak_finder_if.sv
// rtl/window_peak_finder_if.sv - column beat input and peak result handshake bundle
interface window_peak_finder_if #(
    parameter int W    = window_pkg::DEF_W,
    parameter int N    = window_pkg::DEF_N,
    parameter int L    = window_pkg::DEF_L,
    parameter int ROWS = window_pkg::DEF_ROWS
);
    logic                        col_valid;
    logic [N*W-1:0]              col_px;
    logic                        frame_restart;
    logic                        peak_valid;
    logic                        peak_ready;
    logic [W+2*$clog2(N)-1:0]    peak_sum;
    logic [$clog2(L)-1:0]        peak_col;
    logic [$clog2(ROWS)-1:0]     peak_row;
    logic                        peak_overrun;

    modport master (
        output col_valid, col_px, frame_restart, peak_ready,
        input  peak_valid, peak_sum, peak_col, peak_row, peak_overrun
    );

    modport slave (
        input  col_valid, col_px, frame_restart, peak_ready,
        output peak_valid, peak_sum, peak_col, peak_row, peak_overrun
    );
endinterface

// File: rtl/window_peak_finder_column_adder.sv
// rtl/window_peak_finder_column_adder.sv - combinational balanced adder tree summing one N-pixel column
module column_adder #(
    parameter int W = window_pkg::DEF_W,
    parameter int N = window_pkg::DEF_N
) (
    input  logic [N*W-1:0]         px_i,
    output logic [W+$clog2(N)-1:0] sum_o
);
    localparam int SW = W + $clog2(N);

    // Pairwise reduction in place: after each level, lvl[i] holds the sum of a 2*step-wide group.
    always_comb begin
        logic [SW-1:0] lvl [N];
        for (int i = 0; i < N; i++) begin
            lvl[i] = SW'(px_i[W*i +: W]);
        end
        for (int step = 1; step < N; step = step * 2) begin
            for (int i = 0; i < N; i = i + 2 * step) begin
                lvl[i] = lvl[i] + lvl[i + step];
            end
        end
        sum_o = lvl[0];
    end
endmodule

// File: rtl/window_peak_finder.sv
// rtl/window_peak_finder.sv - sliding NxN box-sum over column beats, reports brightest window once per frame
module window_peak_finder
    import window_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int N    = DEF_N,
    parameter int L    = DEF_L,
    parameter int ROWS = DEF_ROWS
) (
    input  logic               clk,
    input  logic               reset,
    window_peak_finder_if.slave bus
);
    localparam int CSW = W + $clog2(N);
    localparam int WSW = W + 2 * $clog2(N);
    localparam int CW  = $clog2(L);
    localparam int RW  = $clog2(ROWS);

    logic [CSW-1:0] col_sum;

    column_adder #(.W(W), .N(N)) u_column_adder (
        .px_i  (bus.col_px),
        .sum_o (col_sum)
    );

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic           beat, col_end, row_end;

    logic           s1_valid_q, s1_valid_d;
    col_beat_t      s1_q, s1_d;
    logic [CW-1:0]  s1_col;
    logic [RW-1:0]  s1_row;
    logic [CSW-1:0] s1_sum;

    logic [CSW-1:0] hist_q [N];
    logic [CSW-1:0] hist_d [N];
    logic [WSW-1:0] win_q, win_d;
    logic           s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [CW-1:0]  s2_col_q, s2_col_d;
    logic [RW-1:0]  s2_row_q, s2_row_d;

    logic           have_best_q, have_best_d;
    logic [WSW-1:0] best_sum_q, best_sum_d;
    logic [CW-1:0]  best_col_q, best_col_d;
    logic [RW-1:0]  best_row_q, best_row_d;
    logic           better, load;

    logic           pv_q, pv_d, pover_q, pover_d;
    logic [WSW-1:0] psum_q, psum_d;
    logic [CW-1:0]  pcol_q, pcol_d;
    logic [RW-1:0]  prow_q, prow_d;

    assign beat    = bus.col_valid && !bus.frame_restart;
    assign col_end = (col_q == CW'(L - 1));
    assign row_end = (row_q == RW'(ROWS - 1));
    assign s1_col  = CW'(s1_q.col);
    assign s1_row  = RW'(s1_q.row);
    assign s1_sum  = CSW'(s1_q.sum);

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        s1_valid_d = beat;
        s1_d       = s1_q;
        if (bus.frame_restart) begin
            col_d = '0;
            row_d = '0;
        end else if (beat) begin
            s1_d.sum  = COLSUM_W'(col_sum);
            s1_d.col  = COL_W'(col_q);
            s1_d.row  = ROW_W'(row_q);
            s1_d.last = col_end && row_end;
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Running window: add the new column, drop the one N columns back; history restarts each row.
    always_comb begin
        hist_d     = hist_q;
        win_d      = win_q;
        s2_valid_d = 1'b0;
        s2_last_d  = s2_last_q;
        s2_col_d   = s2_col_q;
        s2_row_d   = s2_row_q;
        if (bus.frame_restart) begin
            hist_d = '{default: '0};
            win_d  = '0;
        end else if (s1_valid_q) begin
            if (s1_col == '0) begin
                hist_d = '{default: '0};
                win_d  = WSW'(s1_sum);
            end else begin
                for (int i = N - 1; i > 0; i--) begin
                    hist_d[i] = hist_q[i-1];
                end
                win_d = win_q + WSW'(s1_sum) - WSW'(hist_q[N-1]);
            end
            hist_d[0]  = s1_sum;
            s2_valid_d = (s1_col >= CW'(N - 1));
            s2_last_d  = s1_q.last;
            s2_col_d   = s1_col - CW'(N - 1);
            s2_row_d   = s1_row;
        end
    end

    always_comb begin
        better      = !have_best_q || (win_q > best_sum_q);
        load        = s2_valid_q && s2_last_q && !bus.frame_restart;
        have_best_d = have_best_q;
        best_sum_d  = best_sum_q;
        best_col_d  = best_col_q;
        best_row_d  = best_row_q;
        pv_d        = pv_q;
        pover_d     = pover_q;
        psum_d      = psum_q;
        pcol_d      = pcol_q;
        prow_d      = prow_q;

        if (bus.frame_restart || load) begin
            have_best_d = 1'b0;
            best_sum_d  = '0;
            best_col_d  = '0;
            best_row_d  = '0;
        end else if (s2_valid_q && better) begin
            have_best_d = 1'b1;
            best_sum_d  = win_q;
            best_col_d  = s2_col_q;
            best_row_d  = s2_row_q;
        end

        if (load) begin
            pv_d   = 1'b1;
            psum_d = better ? win_q    : best_sum_q;
            pcol_d = better ? s2_col_q : best_col_q;
            prow_d = better ? s2_row_q : best_row_q;
            if (pv_q && !bus.peak_ready) begin
                pover_d = 1'b1;
            end
        end else if (pv_q && bus.peak_ready) begin
            pv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q       <= '0;
            row_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            hist_q      <= '{default: '0};
            win_q       <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_col_q    <= '0;
            s2_row_q    <= '0;
            have_best_q <= 1'b0;
            best_sum_q  <= '0;
            best_col_q  <= '0;
            best_row_q  <= '0;
            pv_q        <= 1'b0;
            pover_q     <= 1'b0;
            psum_q      <= '0;
            pcol_q      <= '0;
            prow_q      <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            hist_q      <= hist_d;
            win_q       <= win_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_col_q    <= s2_col_d;
            s2_row_q    <= s2_row_d;
            have_best_q <= have_best_d;
            best_sum_q  <= best_sum_d;
            best_col_q  <= best_col_d;
            best_row_q  <= best_row_d;
            pv_q        <= pv_d;
            pover_q     <= pover_d;
            psum_q      <= psum_d;
            pcol_q      <= pcol_d;
            prow_q      <= prow_d;
        end
    end

    assign bus.peak_valid   = pv_q;
    assign bus.peak_overrun = pover_q;
    assign bus.peak_sum     = psum_q;
    assign bus.peak_col     = pcol_q;
    assign bus.peak_row     = prow_q;
endmodule

// File: tb/tb_window_peak_finder.sv
// tb/tb_window_peak_finder.sv - directed and randomized checks of window_peak_finder against a frame-level model
module tb_window_peak_finder;
    localparam int W    = 8;
    localparam int N    = 16;
    localparam int L    = 80;
    localparam int ROWS = 4;
    localparam int PXW  = N * W;
    localparam int FRAME = ROWS * L;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_peak_finder_if #(.W(W), .N(N), .L(L), .ROWS(ROWS)) bus ();

    window_peak_finder #(.W(W), .N(N), .L(L), .ROWS(ROWS)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int at;
        int s;
        int c;
        int r;
    } res_t;

    res_t pend[$];
    int   cs [ROWS][L];
    int   mrow = 0, mcol = 0, ecount = 0;
    int   exp_valid = 0, exp_sum = 0, exp_col = 0, exp_row = 0, exp_over = 0;
    int   checks = 0, errors = 0;
    bit   chk_en = 1'b0;
    bit   rnd_ready = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Brute force over every window of the stored frame; strict > keeps the earliest in raster order.
    function automatic res_t frame_best();
        res_t b;
        int   s;
        b.at = 0; b.s = -1; b.c = 0; b.r = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c <= L - N; c++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += cs[r][c+k];
                if (s > b.s) begin
                    b.s = s; b.c = c; b.r = r;
                end
            end
        end
        return b;
    endfunction

    task automatic model_loop();
        logic [PXW-1:0] px;
        int   s;
        res_t b;
        bit   load;
        forever begin
            @(posedge clk);
            ecount++;
            if (!rst_n) begin
                mrow = 0; mcol = 0; pend.delete();
                exp_valid = 0; exp_sum = 0; exp_col = 0; exp_row = 0; exp_over = 0;
            end else begin
                if (bus.frame_restart) begin
                    mrow = 0; mcol = 0; pend.delete();
                end else if (bus.col_valid) begin
                    px = bus.col_px;
                    s  = 0;
                    for (int k = 0; k < N; k++) s += int'(px[k*W +: W]);
                    cs[mrow][mcol] = s;
                    if (mrow == ROWS - 1 && mcol == L - 1) begin
                        b    = frame_best();
                        b.at = ecount + 2;
                        pend.push_back(b);
                    end
                    if (mcol == L - 1) begin
                        mcol = 0;
                        mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
                    end else begin
                        mcol++;
                    end
                end
                load = (pend.size() > 0) && (pend[0].at == ecount);
                if (load) begin
                    if (exp_valid != 0 && !bus.peak_ready) exp_over = 1;
                    exp_valid = 1;
                    exp_sum   = pend[0].s;
                    exp_col   = pend[0].c;
                    exp_row   = pend[0].r;
                    void'(pend.pop_front());
                end else if (exp_valid != 0 && bus.peak_ready) begin
                    exp_valid = 0;
                end
            end
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("peak_valid", int'(bus.peak_valid), exp_valid);
                check("peak_overrun", int'(bus.peak_overrun), exp_over);
                if (exp_valid != 0) begin
                    check("peak_sum", int'(bus.peak_sum), exp_sum);
                    check("peak_col", int'(bus.peak_col), exp_col);
                    check("peak_row", int'(bus.peak_row), exp_row);
                end
            end
        end
    endtask

    function automatic logic [PXW-1:0] make_px(input int mode, input int r, input int c);
        logic [PXW-1:0] px = '0;
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       px[k*W +: W] = 8'd1;
                1:       px[k*W +: W] = (r == 2 && c == 40) ? 8'd255 : 8'd0;
                2:       px[k*W +: W] = 8'd255;
                3:       px[k*W +: W] = 8'($urandom_range(0, 255));
                4:       px[k*W +: W] = (r == 3 && c == 5) ? 8'd10 : 8'd0;
                default: px[k*W +: W] = (r == 1 && c == 10) ? 8'd255 : 8'd0;
            endcase
        end
        return px;
    endfunction

    task automatic drive_cycle(input bit v, input logic [PXW-1:0] px);
        bus.col_valid = v;
        bus.col_px    = v ? px : make_px(3, 0, 0);
        if (rnd_ready) bus.peak_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.col_valid = 1'b0;
    endtask

    task automatic send_beats(input int mode, input int count, input int max_gap);
        int r = 0;
        int c = 0;
        for (int i = 0; i < count; i++) begin
            if (max_gap > 0) repeat ($urandom_range(1, max_gap)) drive_cycle(1'b0, '0);
            drive_cycle(1'b1, make_px(mode, r, c));
            if (c == L - 1) begin
                c = 0;
                r = (r == ROWS - 1) ? 0 : r + 1;
            end else begin
                c++;
            end
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.peak_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.peak_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got no peak_valid within %0d cycles", lat);
        end
    endtask

    task automatic expect_result(input string name, input int s, input int c, input int r);
        check({name, "_sum"}, int'(bus.peak_sum), s);
        check({name, "_col"}, int'(bus.peak_col), c);
        check({name, "_row"}, int'(bus.peak_row), r);
    endtask

    task automatic accept();
        bus.peak_ready = 1'b1;
        @(negedge clk);
        bus.peak_ready = 1'b0;
    endtask

    initial begin
        int lat;
        bus.col_valid     = 1'b0;
        bus.col_px        = '0;
        bus.frame_restart = 1'b0;
        bus.peak_ready    = 1'b0;
        fork
            model_loop();
            monitor_loop();
        join_none

        // Reset with beats toggling
        rst_n = 1'b0;
        @(negedge clk);
        bus.col_valid = 1'b1;
        bus.col_px    = make_px(2, 0, 0);
        @(negedge clk);
        bus.col_valid = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_valid", int'(bus.peak_valid), 0);
        check("reset_overrun", int'(bus.peak_overrun), 0);
        expect_result("reset", 0, 0, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_valid", int'(bus.peak_valid), 0);

        // Uniform frame, tie keeps earliest, latency
        send_beats(0, FRAME, 0);
        wait_result(lat);
        check("latency", lat + 1, 3);
        expect_result("uniform", 256, 0, 0);
        accept();

        // Bright column
        send_beats(1, FRAME, 0);
        wait_result(lat);
        expect_result("bright", 4080, 25, 2);
        accept();

        // Saturation, gapless then gapped
        send_beats(2, FRAME, 0);
        wait_result(lat);
        expect_result("sat", 65280, 0, 0);
        accept();
        send_beats(2, FRAME, 3);
        wait_result(lat);
        expect_result("sat_gaps", 65280, 0, 0);
        accept();

        // Backpressure: pending result, accept coinciding with next load, then overrun
        send_beats(0, FRAME, 0);
        wait_result(lat);
        send_beats(1, FRAME, 0);
        @(negedge clk);
        bus.peak_ready = 1'b1;
        @(negedge clk);
        bus.peak_ready = 1'b0;
        check("same_cycle_valid", int'(bus.peak_valid), 1);
        check("same_cycle_overrun", int'(bus.peak_overrun), 0);
        expect_result("same_cycle", 4080, 25, 2);
        send_beats(4, FRAME, 0);
        repeat (2) @(negedge clk);
        check("overrun_set", int'(bus.peak_overrun), 1);
        expect_result("overrun", 160, 0, 3);
        accept();

        // Restart mid row 1 after a spike, with a discarded beat in the restart cycle
        send_beats(5, L + 30, 0);
        bus.frame_restart = 1'b1;
        bus.col_valid     = 1'b1;
        bus.col_px        = make_px(2, 0, 0);
        @(negedge clk);
        bus.frame_restart = 1'b0;
        bus.col_valid     = 1'b0;
        send_beats(4, FRAME, 0);
        wait_result(lat);
        expect_result("restart", 160, 0, 3);
        check("restart_keeps_overrun", int'(bus.peak_overrun), 1);
        accept();

        // Reset mid-frame discards partial frame and clears overrun
        send_beats(2, 100, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_clears_overrun", int'(bus.peak_overrun), 0);
        send_beats(0, FRAME, 0);
        wait_result(lat);
        expect_result("after_reset", 256, 0, 0);
        accept();

        // Random pixels, gaps and consumer readiness
        rnd_ready = 1'b1;
        repeat (3) send_beats(3, FRAME, 2);
        rnd_ready = 1'b0;
        bus.peak_ready = 1'b0;
        repeat (10) @(negedge clk);
        accept();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
